// File: rtl/io_port_pkg.sv
// Shared register map, status bit positions and the active-low hex-to-7-segment decoder
// used by the MMIO I/O port.
package io_port_pkg;

  // Word index within the 16-byte I/O window (byte offset >> 2).
  typedef enum logic [1:0] {
    IO_STATUS  = 2'd0,
    IO_SWITCH  = 2'd1,
    IO_DISPLAY = 2'd2,
    IO_RSVD    = 2'd3
  } io_reg_e;

  localparam int SW_RDY   = 0;
  localparam int DISP_RDY = 1;
  localparam int OVR      = 2;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, registered one-cycle press pulse.
// Raw rise held steady reaches press after 2+DEBOUNCE_CYCLES edges.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          level_q, level_d, press_q, press_d, armed_q, armed_d;
  logic [1:0]    fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A button held through reset release is not armed until a genuine low sample is seen,
  // so its level may settle high but it never produces a press until released and re-pressed.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & ~sync2_q);
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q & armed_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/mmio_io_port.sv
// MMIO responder: W1C status flags, latched switches, display register and 8-digit 7-seg scanner.
// Optional leading-zero blanking when IO_PORT_ZERO_BLANK_EN is defined.
module mmio_io_port
  import io_port_pkg::*;
#(
  parameter logic [31:0] IO_BASE         = 32'h0000_0080,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          SCAN_DIV        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        io_sel,
  input  logic        BTNL,
  input  logic        BTNR,
  input  logic [15:0] SW,
  output logic [7:0]  AN,
  output logic        DP,
  output logic [6:0]  A2G
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic          r_press, l_press, r_level_unused, l_level_unused;
  logic [1:0]    adr_lsb_unused;
  logic [15:0]   sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d, sw_lat_q, sw_lat_d;
  logic [31:0]   disp_q, disp_d;
  logic          sw_rdy_q, sw_rdy_d, disp_rdy_q, disp_rdy_d, ovr_q, ovr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    a2g_q, a2g_d;
  logic          wr_en, st_wr, dp_wr;
  io_reg_e       reg_sel;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnr (
    .clk(clk), .reset(reset), .raw(BTNR), .level(r_level_unused), .press(r_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnl (
    .clk(clk), .reset(reset), .raw(BTNL), .level(l_level_unused), .press(l_press)
  );

  assign adr_lsb_unused = adr[1:0];
  assign io_sel  = (adr[31:4] == IO_BASE[31:4]);
  assign reg_sel = io_reg_e'(adr[3:2]);
  assign wr_en   = memwrite & io_sel;
  assign st_wr   = wr_en && (reg_sel == IO_STATUS);
  assign dp_wr   = wr_en && (reg_sel == IO_DISPLAY);

  always_comb begin
    readdata = '0;
    if (io_sel) begin
      case (reg_sel)
        IO_STATUS: begin
          readdata[SW_RDY]   = sw_rdy_q;
          readdata[DISP_RDY] = disp_rdy_q;
          readdata[OVR]      = ovr_q;
        end
        IO_SWITCH:  readdata = {16'h0000, sw_lat_q};
        IO_DISPLAY: readdata = disp_q;
        default:    readdata = '0;
      endcase
    end
  end

  // Clears are applied first so a press arriving on the same edge wins.
  always_comb begin
    sw_s1_d    = SW;
    sw_s2_d    = sw_s1_q;
    sw_rdy_d   = sw_rdy_q & ~(st_wr & writedata[SW_RDY]);
    disp_rdy_d = disp_rdy_q & ~(st_wr & writedata[DISP_RDY]) & ~dp_wr;
    ovr_d      = ovr_q & ~(st_wr & writedata[OVR]);
    sw_lat_d   = sw_lat_q;
    disp_d     = dp_wr ? writedata : disp_q;
    if (r_press) begin
      sw_lat_d = sw_s2_q;
      sw_rdy_d = 1'b1;
      if (sw_rdy_q) ovr_d = 1'b1;
    end
    if (l_press) disp_rdy_d = 1'b1;
  end

`ifdef IO_PORT_ZERO_BLANK_EN
  logic [2:0] msd;
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (disp_q[4*i +: 4] != 4'h0) msd = 3'(i);
    end
  end
`endif

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end
    an_d  = ~(8'b1 << idx_q);
    a2g_d = hex7seg(disp_q[{idx_q, 2'b00} +: 4]);
`ifdef IO_PORT_ZERO_BLANK_EN
    if (idx_q > msd) begin
      an_d  = 8'hFF;
      a2g_d = 7'h7F;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      sw_lat_q   <= '0;
      disp_q     <= '0;
      sw_rdy_q   <= 1'b0;
      disp_rdy_q <= 1'b0;
      ovr_q      <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      an_q       <= 8'hFF;
      a2g_q      <= 7'h7F;
    end else begin
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      sw_lat_q   <= sw_lat_d;
      disp_q     <= disp_d;
      sw_rdy_q   <= sw_rdy_d;
      disp_rdy_q <= disp_rdy_d;
      ovr_q      <= ovr_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      a2g_q      <= a2g_d;
    end
  end

  assign AN  = an_q;
  assign A2G = a2g_q;
  assign DP  = 1'b1;

endmodule

// File: tb/tb_mmio_io_port.sv
// Bench for mmio_io_port: directed stimulus, a behavioural reference model checked every cycle,
// and literal expectations for the key timing and register values.
module tb_mmio_io_port;

  localparam int DB = 4;
  localparam int SD = 4;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0, reset = 1'b0, memwrite = 1'b0, BTNL = 1'b0, BTNR = 1'b0;
  logic [31:0] adr = 32'h0, writedata = 32'h0;
  logic [15:0] SW = 16'h0;
  logic [31:0] readdata;
  logic        io_sel, DP;
  logic [7:0]  AN;
  logic [6:0]  A2G;
  int total = 0, bad = 0;

  mmio_io_port #(.IO_BASE(32'h80), .DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr), .writedata(writedata),
    .readdata(readdata), .io_sel(io_sel), .BTNL(BTNL), .BTNR(BTNR), .SW(SW),
    .AN(AN), .DP(DP), .A2G(A2G)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          k;
  logic [31:0] m_disp;
  logic [15:0] m_swlat, swh1, swh2;
  logic        m_swr, m_dr, m_ovr;
  logic [7:0]  m_an;
  logic [6:0]  m_a2g;
  logic [1:0]  rh [2];
  logic        db_lvl [2], db_last [2], db_arm [2], pend [2];
  int          db_run [2];

  task automatic model_reset();
    k = 0; m_disp = 0; m_swlat = 0; swh1 = 0; swh2 = 0;
    m_swr = 0; m_dr = 0; m_ovr = 0; m_an = 8'hFF; m_a2g = 7'h7F;
    for (int b = 0; b < 2; b++) begin
      rh[b] = 2'b00; db_lvl[b] = 0; db_last[b] = 0; db_arm[b] = 0; pend[b] = 0; db_run[b] = 0;
    end
  endtask

  // Debounced level = value of the latest run of >= DB equal samples; press = rise while armed.
  task automatic db_step(input int b, input logic samp, input logic valid, output logic p);
    p = 1'b0;
    if (samp == db_last[b]) db_run[b]++;
    else begin db_run[b] = 1; db_last[b] = samp; end
    if (samp != db_lvl[b] && db_run[b] >= DB) begin
      db_lvl[b] = samp;
      p = samp && db_arm[b];
    end
    if (valid && !samp) db_arm[b] = 1'b1;
  endtask

  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [15:0] sw, input logic br, input logic bl);
    int   sidx;
    logic w, old, p;
    sidx  = (k / SD) % 8;
    m_an  = ~(8'd1 << sidx);
    m_a2g = SEG[m_disp[4*sidx +: 4]];
`ifdef IO_PORT_ZERO_BLANK_EN
    if (sidx > 0 && (m_disp >> (4 * sidx)) == 0) begin m_an = 8'hFF; m_a2g = 7'h7F; end
`endif
    k++;
    w   = we && (a[31:4] == 28'h8);
    old = m_swr;
    if (w && a[3:2] == 2'd0) begin
      if (wd[0]) m_swr = 0;
      if (wd[1]) m_dr = 0;
      if (wd[2]) m_ovr = 0;
    end
    if (w && a[3:2] == 2'd2) begin m_disp = wd; m_dr = 0; end
    if (pend[0]) begin m_swlat = swh2; m_swr = 1; if (old) m_ovr = 1; end
    if (pend[1]) m_dr = 1;
    db_step(0, rh[0][1], k >= 3, p); pend[0] = p;
    db_step(1, rh[1][1], k >= 3, p); pend[1] = p;
    rh[0] = {rh[0][0], br};
    rh[1] = {rh[1][0], bl};
    swh2 = swh1; swh1 = sw;
  endtask

  logic        c_rst, c_we, c_br, c_bl;
  logic [31:0] c_adr, c_wd;
  logic [15:0] c_sw;

  initial begin
    logic [31:0] exp_rd;
    model_reset();
    forever begin
      @(posedge clk);
      c_rst = reset; c_we = memwrite; c_adr = adr; c_wd = writedata;
      c_sw = SW; c_br = BTNR; c_bl = BTNL;
      if (c_rst) model_edge(c_we, c_adr, c_wd, c_sw, c_br, c_bl);
      @(negedge clk);
      if (!reset) model_reset();
      exp_rd = 0;
      if (adr[31:4] == 28'h8) begin
        case (adr[3:2])
          2'd0: exp_rd = {29'h0, m_ovr, m_dr, m_swr};
          2'd1: exp_rd = {16'h0, m_swlat};
          2'd2: exp_rd = m_disp;
          default: exp_rd = 0;
        endcase
      end
      chk("m_io_sel", io_sel, adr[31:4] == 28'h8);
      chk("m_readdata", readdata, exp_rd);
      chk("m_AN", AN, m_an);
      chk("m_A2G", A2G, m_a2g);
      chk("m_DP", DP, 1'b1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt();
    @(posedge clk); #2;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    adr = a; memwrite = 0;
    @(negedge clk);
    chk(name, readdata, exp);
    nxt();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    adr = a; writedata = d; memwrite = 1;
    nxt();
    memwrite = 0;
  endtask

  task automatic rise_timing(input string name);
    adr = 32'h80; BTNR = 1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("%s_edge%0d", name, i), readdata[0], i == 7);
    end
    nxt();
  endtask

  task automatic pulse_r(input logic [15:0] v);
    SW = v; BTNR = 1; repeat (10) nxt(); BTNR = 0; repeat (8) nxt();
  endtask

  task automatic pulse_l();
    BTNL = 1; repeat (10) nxt(); BTNL = 0; repeat (8) nxt();
  endtask

  // Leaves the caller at the negedge where AN first becomes target.
  task automatic wait_an(input logic [7:0] target, input string name);
    logic [7:0] prev;
    logic       found;
    prev = target; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (AN == target && prev != target) found = 1;
      prev = AN;
    end
    if (!found) chk(name, 0, 1);
  endtask

  initial begin
    // 1: reset values, window decode
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_AN", AN, 8'hFF);
    chk("rst_A2G", A2G, 7'h7F);
    chk("rst_DP", DP, 1'b1);
    nxt(); reset = 1;
    adr = 32'h80;
    @(negedge clk);
    chk("t1_io_sel_80", io_sel, 1'b1);
    chk("t1_rd_80", readdata, 32'h0);
    nxt(); adr = 32'h40;
    @(negedge clk);
    chk("t1_io_sel_40", io_sel, 1'b0);
    chk("t1_rd_40", readdata, 32'h0);
    nxt();

    // 2: debounced BTNR latches SW after 7 edges; W1C clears
    SW = 16'h1234;
    rise_timing("t2_lat");
    repeat (3) nxt(); BTNR = 0; repeat (8) nxt();
    rd(32'h84, 32'h1234, "t2_switch");
    wr(32'h80, 32'h1);
    rd(32'h80, 32'h0, "t2_cleared");

    // 3: bounce rejected; double press sets overrun
    for (int i = 0; i < 6; i++) begin BTNR = ~BTNR; nxt(); end
    BTNR = 0; repeat (8) nxt();
    rd(32'h80, 32'h0, "t3_bounce");
    pulse_r(16'h5555);
    pulse_r(16'hBEEF);
    rd(32'h80, 32'h5, "t3_ovr");
    rd(32'h84, 32'hBEEF, "t3_switch");
    wr(32'h80, 32'h4);
    rd(32'h80, 32'h1, "t3_ovr_clr");

    // 4: display handshake and scan
    pulse_l();
    rd(32'h80, 32'h3, "t4_disp_rdy");
    wr(32'h88, 32'h0000_00A5);
    rd(32'h80, 32'h1, "t4_disp_clr");
    rd(32'h88, 32'hA5, "t4_disp_rd");
    wait_an(8'hFE, "t4_wait_d0");
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("t4_d0_AN", AN, 8'hFE);
      chk("t4_d0_A2G", A2G, 7'h12);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_d1_AN", AN, 8'hFD);
      chk("t4_d1_A2G", A2G, 7'h08);
    end
    @(negedge clk);
`ifdef IO_PORT_ZERO_BLANK_EN
    chk("t4_d2_AN", AN, 8'hFF);
    chk("t4_d2_A2G", A2G, 7'h7F);
`else
    chk("t4_d2_AN", AN, 8'hFB);
    chk("t4_d2_A2G", A2G, 7'h40);
`endif
    nxt();

    // 5: press and W1C on the same edge; index wrap
    wr(32'h80, 32'h7);
    rd(32'h80, 32'h0, "t5_all_clr");
    adr = 32'h80; BTNR = 1; repeat (6) nxt();
    wr(32'h80, 32'h1);
    rd(32'h80, 32'h1, "t5_set_wins");
    BTNR = 0; repeat (8) nxt();
    wr(32'h88, 32'hF000_00A5);
    wait_an(8'h7F, "t5_wait_d7");
    chk("t5_d7_A2G", A2G, 7'h0E);
    repeat (4) @(negedge clk);
    chk("t5_wrap_AN", AN, 8'hFE);
    chk("t5_wrap_A2G", A2G, 7'h12);
    nxt();

    // 6: reset mid-debounce with the button held
    BTNR = 1; repeat (4) nxt();
    reset = 0;
    @(negedge clk);
    chk("t6_rst_AN", AN, 8'hFF);
    chk("t6_rst_A2G", A2G, 7'h7F);
    nxt(); nxt(); reset = 1;
    repeat (12) nxt();
    rd(32'h80, 32'h0, "t6_held_no_press");
    BTNR = 0; repeat (10) nxt();
    rise_timing("t6_repress");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
